// File: rtl/pc_unit.sv
// Fetch PC register and next-PC selection: execute-stage redirect with
// misaligned-target trap, stall hold, and a circular return-address stack.
module pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = 'h10000,
  parameter logic [XLEN-1:0] TRAP_VEC   = 'h00100,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter int unsigned     STEP       = 4,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redir_valid,
  input  logic                         redir_is_jalr,
  input  logic                         redir_taken,
  input  logic [XLEN-1:0]              redir_pc,
  input  logic [XLEN-1:0]              redir_imm,
  input  logic [XLEN-1:0]              redir_rs1,
  input  logic                         ras_push,
  input  logic [XLEN-1:0]              ras_push_addr,
  input  logic                         ras_pop,
  output logic [XLEN-1:0]              pc,
  output logic [XLEN-1:0]              npc,
  output logic                         trap_valid,
  output logic [XLEN-1:0]              trap_addr,
  output logic                         ras_empty,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   top;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            ras_active;
  logic            do_push;
  logic            do_pop;

  always_comb begin
    jalr_sum = redir_rs1 + redir_imm;
    if (redir_is_jalr)
      target = {jalr_sum[XLEN-1:1], 1'b0};
    else if (redir_taken)
      target = redir_pc + redir_imm;
    else
      target = redir_pc + XLEN'(STEP);
    misaligned = |target[ALIGN_BITS-1:0];
  end

  assign ras_empty  = (ras_count == '0);
  assign ras_active = !redir_valid && !stall;
  assign do_pop     = ras_active && ras_pop && !ras_empty;
  assign do_push    = ras_active && ras_push;

  always_comb begin
    npc = pc + XLEN'(STEP);
    if (redir_valid && misaligned)
      npc = TRAP_VEC;
    else if (redir_valid)
      npc = target;
    else if (stall)
      npc = pc;
    else if (do_pop)
      npc = ras_mem[top];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VEC;
      trap_valid <= 1'b0;
      trap_addr  <= '0;
    end else begin
      pc         <= npc;
      trap_valid <= redir_valid && misaligned;
      if (redir_valid && misaligned)
        trap_addr <= target;
    end
  end

  // Push+pop together replaces the top in place: the popped entry is consumed
  // by npc and the pushed one takes its slot, so pointer and count stay put.
  always_ff @(posedge clk) begin
    if (rst) begin
      top       <= '0;
      ras_count <= '0;
    end else if (do_push && do_pop) begin
      top       <= top;
    end else if (do_push) begin
      top <= top + PW'(1);
      if (ras_count != CW'(RAS_DEPTH))
        ras_count <= ras_count + CW'(1);
    end else if (do_pop) begin
      top       <= top - PW'(1);
      ras_count <= ras_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push && do_pop)
        ras_mem[top] <= ras_push_addr;
      else if (do_push)
        ras_mem[top + PW'(1)] <= ras_push_addr;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h10000;
  localparam logic [31:0] TV = 32'h100;

  logic        clk = 1'b0;
  logic        rst, stall, redir_valid, redir_is_jalr, redir_taken;
  logic [31:0] redir_pc, redir_imm, redir_rs1, ras_push_addr;
  logic        ras_push, ras_pop;

  logic [31:0] pc, npc, trap_addr, pc1, npc1, trap_addr1;
  logic        trap_valid, ras_empty, trap_valid1, ras_empty1;
  logic [2:0]  ras_count, ras_count1;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_pc, m_trap_addr;
  logic        m_trap_valid;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VEC(32'h10000), .TRAP_VEC(32'h100),
            .ALIGN_BITS(2), .STEP(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_is_jalr(redir_is_jalr), .redir_taken(redir_taken),
    .redir_pc(redir_pc), .redir_imm(redir_imm), .redir_rs1(redir_rs1),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc(pc), .npc(npc), .trap_valid(trap_valid), .trap_addr(trap_addr),
    .ras_empty(ras_empty), .ras_count(ras_count));

  pc_unit #(.XLEN(32), .RESET_VEC(32'h10000), .TRAP_VEC(32'h100),
            .ALIGN_BITS(1), .STEP(4), .RAS_DEPTH(4)) dut_a1 (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_is_jalr(redir_is_jalr), .redir_taken(redir_taken),
    .redir_pc(redir_pc), .redir_imm(redir_imm), .redir_rs1(redir_rs1),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc(pc1), .npc(npc1), .trap_valid(trap_valid1), .trap_addr(trap_addr1),
    .ras_empty(ras_empty1), .ras_count(ras_count1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tgt();
    if (redir_is_jalr) return (redir_rs1 + redir_imm) & ~32'h1;
    if (redir_taken)   return redir_pc + redir_imm;
    return redir_pc + 32'd4;
  endfunction

  function automatic logic [31:0] model_npc();
    logic [31:0] t = tgt();
    if (redir_valid) return (t[1:0] != 2'b00) ? TV : t;
    if (stall)       return m_pc;
    if (ras_pop && m_ras.size() > 0) return m_ras[m_ras.size()-1];
    return m_pc + 32'd4;
  endfunction

  task automatic model_step(input logic [31:0] n);
    logic [31:0] t = tgt();
    if (rst) begin
      m_pc = RV; m_trap_valid = 1'b0; m_trap_addr = '0; m_ras.delete();
      return;
    end
    m_pc         = n;
    m_trap_valid = redir_valid && (t[1:0] != 2'b00);
    if (m_trap_valid) m_trap_addr = t;
    if (!redir_valid && !stall) begin
      if (ras_push && ras_pop && m_ras.size() > 0)
        m_ras[m_ras.size()-1] = ras_push_addr;
      else if (ras_push) begin
        m_ras.push_back(ras_push_addr);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (ras_pop && m_ras.size() > 0)
        void'(m_ras.pop_back());
    end
  endtask

  // Compare DUT against model; called once per cycle after inputs settle.
  task automatic check_now();
    #1;
    chk("pc", pc, m_pc);
    if (!rst) chk("npc", npc, model_npc());
    chk("trap_valid", 32'(trap_valid), 32'(m_trap_valid));
    chk("trap_addr", trap_addr, m_trap_addr);
    chk("ras_count", 32'(ras_count), m_ras.size());
    chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
  endtask

  task automatic advance();
    logic [31:0] n = model_npc();
    @(posedge clk);
    model_step(n);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; stall = 0; redir_valid = 0; redir_is_jalr = 0; redir_taken = 0;
    redir_pc = '0; redir_imm = '0; redir_rs1 = '0;
    ras_push = 0; ras_pop = 0; ras_push_addr = '0;
  endtask

  task automatic push(input logic [31:0] a, input int exp_cnt);
    idle(); ras_push = 1; ras_push_addr = a;
    check_now(); advance();
    chk("push_count", 32'(ras_count), exp_cnt);
  endtask

  initial begin
    logic [31:0] pushes [5];
    logic [31:0] pops [4];
    pushes = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};
    pops   = '{32'hE0, 32'hD0, 32'hC0, 32'hB0};

    idle(); rst = 1;
    @(negedge clk);
    model_step('0);
    advance();
    idle();

    // Reset then free-running
    check_now();
    chk("rst_pc", pc, 32'h10000);
    chk("rst_trap", 32'(trap_valid), 0);
    chk("rst_empty", 32'(ras_empty), 1);
    for (int i = 1; i <= 3; i++) begin
      advance(); check_now();
      chk("seq_pc", pc, 32'h10000 + 32'(4 * i));
    end

    // Stall, then redirect under stall
    stall = 1; check_now(); advance();
    chk("stall_hold", pc, 32'h1000C);
    redir_valid = 1; redir_taken = 1; redir_pc = 32'h10000; redir_imm = 32'h40;
    check_now(); advance();
    chk("redir_under_stall", pc, 32'h10040);

    // JALR misaligned target: trap on ALIGN_BITS=2, no trap on ALIGN_BITS=1
    idle(); redir_valid = 1; redir_is_jalr = 1; redir_rs1 = 32'h20001; redir_imm = 32'h2;
    check_now();
    chk("trap_npc", npc, TV);
    chk("a1_npc", npc1, 32'h20002);
    advance();
    chk("trap_pc", pc, TV);
    chk("trap_pulse", 32'(trap_valid), 1);
    chk("trap_addr", trap_addr, 32'h20002);
    chk("a1_pc", pc1, 32'h20002);
    chk("a1_no_trap", 32'(trap_valid1), 0);
    idle(); check_now(); advance();
    chk("trap_one_cycle", 32'(trap_valid), 0);
    chk("trap_addr_hold", trap_addr, 32'h20002);

    // RAS overflow then drain past empty
    for (int i = 0; i < 5; i++) push(pushes[i], (i < 4) ? i + 1 : 4);
    for (int i = 0; i < 5; i++) begin
      idle(); ras_pop = 1; check_now();
      chk("pop_npc", npc, (i < 4) ? pops[i] : m_pc + 32'd4);
      advance();
      chk("pop_count", 32'(ras_count), (i < 4) ? 3 - i : 0);
    end

    // Push+pop in the same cycle
    push(32'hA0, 1); push(32'hB0, 2);
    idle(); ras_push = 1; ras_pop = 1; ras_push_addr = 32'hF0; check_now();
    chk("pp_npc", npc, 32'hB0);
    advance();
    chk("pp_count", 32'(ras_count), 2);
    idle(); ras_pop = 1; check_now();
    chk("pp_next_pop", npc, 32'hF0);
    advance();

    // PC wrap and not-taken redirect
    idle(); redir_valid = 1; redir_taken = 1; redir_pc = 32'h0; redir_imm = 32'hFFFFFFFC;
    check_now(); advance();
    chk("wrap_pre", pc, 32'hFFFFFFFC);
    idle(); check_now(); advance();
    chk("wrap_pc", pc, 32'h0);
    redir_valid = 1; redir_pc = 32'h200; check_now();
    chk("nt_npc", npc, 32'h204);
    advance();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst           = ($urandom_range(0, 199) == 0);
      stall         = ($urandom_range(0, 7) == 0);
      redir_valid   = ($urandom_range(0, 7) == 0);
      redir_is_jalr = $urandom_range(0, 1);
      redir_taken   = $urandom_range(0, 1);
      redir_pc      = $urandom & ((($urandom_range(0, 3) == 0)) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      redir_imm     = 32'($signed($urandom_range(0, 511)) - 256);
      redir_rs1     = $urandom;
      ras_push      = ($urandom_range(0, 3) == 0);
      ras_pop       = ($urandom_range(0, 3) == 0);
      ras_push_addr = $urandom & 32'hFFFFFFFC;
      check_now();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
